// File: rtl/data_mem_port.sv
// Load/store unit front end for a byte-write data RAM.
// One outstanding transaction; handles alignment, lane steering and extension.
module data_mem_port #(
  parameter int ADDR_WIDTH   = 9,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [31:0]           req_addr_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_en_o,
  output logic [3:0]            mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_din_o,
  input  logic [31:0]           mem_dout_i,
  output logic                  mem_regce_o,
  output logic                  mem_rst_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [1:0] LAST = 2'(READ_LATENCY - 1);

  state_t      state_q;
  state_t      state_d;
  logic        accept;
  logic        req_err;
  logic        cap;
  logic        sz_b;
  logic        sz_h;
  logic        sz_w;
  logic [3:0]  be;
  logic [31:0] din;
  logic [1:0]  cnt_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  assign sz_b = (req_size_i == 2'b00);
  assign sz_h = (req_size_i == 2'b01);
  assign sz_w = (req_size_i == 2'b10);

  always_comb begin
    req_err = |req_addr_i[31:ADDR_WIDTH+2];
    be      = 4'b0000;
    din     = req_wdata_i;
    unique case (1'b1)
      sz_b: begin
        be  = 4'b0001 << req_addr_i[1:0];
        din = {4{req_wdata_i[7:0]}};
      end
      sz_h: begin
        req_err = req_err | req_addr_i[0];
        be      = req_addr_i[1] ? 4'b1100 : 4'b0011;
        din     = {2{req_wdata_i[15:0]}};
      end
      sz_w: begin
        req_err = req_err | (req_addr_i[1:0] != 2'b00);
        be      = 4'b1111;
      end
      default: req_err = 1'b1;
    endcase
  end

  assign accept = req_valid_i && (state_q == IDLE);
  assign cap    = (state_q == WAIT) && (cnt_q == LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (req_we_i || req_err) ? RESP : WAIT;
      WAIT: if (cap) state_d = RESP;
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    rsp_valid_o = (state_q == RESP);
    mem_en_o    = accept && !req_err;
    mem_we_o    = (mem_en_o && req_we_i) ? be : 4'b0000;
  end

  assign mem_addr_o  = req_addr_i[ADDR_WIDTH+1:2];
  assign mem_din_o   = din;
  assign mem_regce_o = 1'b1;
  assign mem_rst_o   = rst_i;

  // Lane selection uses the offset captured at accept, not the live bus.
  assign ld_b = mem_dout_i[{off_q, 3'b000} +: 8];
  assign ld_h = off_q[1] ? mem_dout_i[31:16] : mem_dout_i[15:0];

  always_comb begin
    unique case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & ld_b[7]}}, ld_b};
      2'b01:   ld_ext = {{16{~uns_q & ld_h[15]}}, ld_h};
      default: ld_ext = mem_dout_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= 2'd0;
      off_q   <= 2'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q   <= 2'd0;
        off_q   <= req_addr_i[1:0];
        size_q  <= req_size_i;
        uns_q   <= req_unsigned_i;
        rdata_q <= 32'd0;
        err_q   <= req_err;
      end
      if (state_q == WAIT) begin
        cnt_q <= cnt_q + 2'd1;
        if (cap) rdata_q <= ld_ext;
      end
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule
